// File: rtl/gpio_pkg.sv
// Shared register map definitions for the memory-mapped GPIO bank.
// Each port occupies one 32-byte window; A[4:2] selects the register within it.
package gpio_pkg;

    localparam int PORT_STRIDE_BYTES = 32;

    localparam logic [2:0] OFF_DATA    = 3'd0;
    localparam logic [2:0] OFF_DIR     = 3'd1;
    localparam logic [2:0] OFF_RISE_EN = 3'd2;
    localparam logic [2:0] OFF_FALL_EN = 3'd3;
    localparam logic [2:0] OFF_STATUS  = 3'd4;
    localparam logic [2:0] OFF_PIN     = 3'd5;

    typedef enum logic [2:0] {
        REG_DATA    = OFF_DATA,
        REG_DIR     = OFF_DIR,
        REG_RISE_EN = OFF_RISE_EN,
        REG_FALL_EN = OFF_FALL_EN,
        REG_STATUS  = OFF_STATUS,
        REG_PIN     = OFF_PIN,
        REG_RSVD6   = 3'd6,
        REG_RSVD7   = 3'd7
    } reg_idx_e;

endpackage

// File: rtl/mmio_gpio_bank_if.sv
// CPU-side memory bus seen by the GPIO bank: select, write strobe, address, data.
interface mmio_gpio_bank_if;
    logic        Sel;
    logic        WE;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;

    modport master (output Sel, output WE, output A, output WD, input RD);
    modport slave  (input Sel, input WE, input A, input WD, output RD);
endinterface

// File: rtl/gpio_port.sv
// One GPIO port: direction/data registers, input synchroniser, edge capture
// into write-1-to-clear status, and the port's interrupt request.
module gpio_port
    import gpio_pkg::*;
#(
    parameter int PORT_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PORT_WIDTH-1:0] pin_i,
    input  logic                  wr_en_i,
    input  reg_idx_e              wr_reg_i,
    input  logic [PORT_WIDTH-1:0] wr_data_i,
    output logic [PORT_WIDTH-1:0] data_rd_o,
    output logic [PORT_WIDTH-1:0] dir_o,
    output logic [PORT_WIDTH-1:0] rise_en_o,
    output logic [PORT_WIDTH-1:0] fall_en_o,
    output logic [PORT_WIDTH-1:0] status_o,
    output logic [PORT_WIDTH-1:0] pin_o,
    output logic [PORT_WIDTH-1:0] port_out_o,
    output logic                  irq_o
);

    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    localparam int CNT_W      = $clog2(ARM_CYCLES);

    logic [SYNC_STAGES-1:0][PORT_WIDTH-1:0] sync_q;
    logic [PORT_WIDTH-1:0] pin_sync, prev_q;
    logic [PORT_WIDTH-1:0] data_q, data_d, dir_q, dir_d;
    logic [PORT_WIDTH-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [PORT_WIDTH-1:0] status_q, status_d;
    logic [PORT_WIDTH-1:0] w1c_mask, rise, fall;
    logic [CNT_W-1:0]      arm_cnt_q, arm_cnt_d;
    logic                  armed_q, armed_d;

    assign pin_sync = sync_q[SYNC_STAGES-1];

    // Edges stay masked until the synchroniser and prev flop hold real pin data,
    // so a pin held high through reset never looks like a rising edge.
    assign rise = pin_sync & ~prev_q & rise_en_q & {PORT_WIDTH{armed_q}};
    assign fall = ~pin_sync & prev_q & fall_en_q & {PORT_WIDTH{armed_q}};

    always_comb begin
        data_d    = data_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c_mask  = '0;
        if (wr_en_i) begin
            case (wr_reg_i)
                REG_DATA:    data_d    = wr_data_i;
                REG_DIR:     dir_d     = wr_data_i;
                REG_RISE_EN: rise_en_d = wr_data_i;
                REG_FALL_EN: fall_en_d = wr_data_i;
                REG_STATUS:  w1c_mask  = wr_data_i;
                default:     w1c_mask  = '0;
            endcase
        end
        // New edges are OR-ed in after the clear so a coincident set wins.
        status_d  = (status_q & ~w1c_mask) | rise | fall;
        armed_d   = armed_q | (arm_cnt_q == CNT_W'(ARM_CYCLES - 1));
        arm_cnt_d = armed_q ? arm_cnt_q : arm_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            prev_q    <= '0;
            data_q    <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            arm_cnt_q <= '0;
            armed_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q    <= pin_sync;
            data_q    <= data_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            arm_cnt_q <= arm_cnt_d;
            armed_q   <= armed_d;
        end
    end

    assign data_rd_o  = (data_q & dir_q) | (pin_sync & ~dir_q);
    assign dir_o      = dir_q;
    assign rise_en_o  = rise_en_q;
    assign fall_en_o  = fall_en_q;
    assign status_o   = status_q;
    assign pin_o      = pin_sync;
    assign port_out_o = data_q & dir_q;
    assign irq_o      = |status_q;

endmodule

// File: rtl/mmio_gpio_bank.sv
// NUM_PORTS GPIO ports on the CPU memory bus: address decode, combinational
// read mux, IRQ reduction and flattened tap views for the peek display.
module mmio_gpio_bank
    import gpio_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int PORT_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            CLK,
    input  logic                            reset,
    mmio_gpio_bank_if.slave                 bus,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0] PortIn,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] PortOut,
    output logic                            IRQ,
    output logic [NUM_PORTS*32-1:0]         TapData,
    output logic [NUM_PORTS*32-1:0]         TapControl
);

    localparam int PORT_LSB = $clog2(PORT_STRIDE_BYTES);

    logic [2:0]                     port_idx;
    reg_idx_e                       reg_idx;
    logic [NUM_PORTS-1:0][31:0]     rd_port;
    logic [NUM_PORTS-1:0]           irq_port;
    logic [31:0]                    rd_mux;
    logic                           unused_bits;

    assign port_idx    = bus.A[PORT_LSB +: 3];
    assign reg_idx     = reg_idx_e'(bus.A[4:2]);
    assign unused_bits = ^{bus.A[31:8], bus.A[1:0], bus.WD};

    // Port indices with no instance simply never match, so they read 0 and drop writes.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        localparam logic [2:0] PORT_ID = 3'(gi);

        logic                  hit;
        logic                  wr_en;
        logic [PORT_WIDTH-1:0] data_rd, dir, rise_en, fall_en, status, pin;
        logic [31:0]           rd_word, tap_data_w, tap_ctrl_w;

        assign hit   = bus.Sel && (port_idx == PORT_ID);
        assign wr_en = hit && bus.WE;

        gpio_port #(
            .PORT_WIDTH  (PORT_WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_port (
            .clk        (CLK),
            .rst        (reset),
            .pin_i      (PortIn[gi*PORT_WIDTH +: PORT_WIDTH]),
            .wr_en_i    (wr_en),
            .wr_reg_i   (reg_idx),
            .wr_data_i  (bus.WD[PORT_WIDTH-1:0]),
            .data_rd_o  (data_rd),
            .dir_o      (dir),
            .rise_en_o  (rise_en),
            .fall_en_o  (fall_en),
            .status_o   (status),
            .pin_o      (pin),
            .port_out_o (PortOut[gi*PORT_WIDTH +: PORT_WIDTH]),
            .irq_o      (irq_port[gi])
        );

        always_comb begin
            rd_word = '0;
            if (hit) begin
                case (reg_idx)
                    REG_DATA:    rd_word[PORT_WIDTH-1:0] = data_rd;
                    REG_DIR:     rd_word[PORT_WIDTH-1:0] = dir;
                    REG_RISE_EN: rd_word[PORT_WIDTH-1:0] = rise_en;
                    REG_FALL_EN: rd_word[PORT_WIDTH-1:0] = fall_en;
                    REG_STATUS:  rd_word[PORT_WIDTH-1:0] = status;
                    REG_PIN:     rd_word[PORT_WIDTH-1:0] = pin;
                    default:     rd_word = '0;
                endcase
            end
            tap_data_w = '0;
            tap_data_w[PORT_WIDTH-1:0] = data_rd;
            tap_ctrl_w = '0;
            tap_ctrl_w[PORT_WIDTH-1:0] = dir;
        end

        assign rd_port[gi]              = rd_word;
        assign TapData[gi*32 +: 32]     = tap_data_w;
        assign TapControl[gi*32 +: 32]  = tap_ctrl_w;
    end

    always_comb begin
        rd_mux = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rd_mux = rd_mux | rd_port[p];
        end
    end

    assign bus.RD = rd_mux;
    assign IRQ    = |irq_port;

endmodule

// File: tb/tb_mmio_gpio_bank.sv
// Bench for mmio_gpio_bank: default 2x8 instance against a behavioural model,
// plus a 3x12 instance for port-decode and register-width masking.
module tb_mmio_gpio_bank;

    localparam int NP  = 2;
    localparam int PW  = 8;
    localparam int SS  = 2;
    localparam int NPW = 3;
    localparam int PWW = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mmio_gpio_bank_if bus ();
    mmio_gpio_bank_if bus_w ();

    logic [NP*PW-1:0]   port_in, port_out;
    logic               irq;
    logic [NP*32-1:0]   tap_data, tap_ctrl;
    logic [NPW*PWW-1:0] port_in_w, port_out_w;
    logic               irq_w;
    logic [NPW*32-1:0]  tap_data_w, tap_ctrl_w;

    mmio_gpio_bank #(.NUM_PORTS(NP), .PORT_WIDTH(PW), .SYNC_STAGES(SS)) dut (
        .CLK(clk), .reset(rst), .bus(bus), .PortIn(port_in), .PortOut(port_out),
        .IRQ(irq), .TapData(tap_data), .TapControl(tap_ctrl)
    );

    mmio_gpio_bank #(.NUM_PORTS(NPW), .PORT_WIDTH(PWW), .SYNC_STAGES(SS)) dut_w (
        .CLK(clk), .reset(rst), .bus(bus_w), .PortIn(port_in_w), .PortOut(port_out_w),
        .IRQ(irq_w), .TapData(tap_data_w), .TapControl(tap_ctrl_w)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: register file per port plus the history of sampled inputs.
    logic [PW-1:0]    m_data [NP];
    logic [PW-1:0]    m_dir  [NP];
    logic [PW-1:0]    m_ren  [NP];
    logic [PW-1:0]    m_fen  [NP];
    logic [PW-1:0]    m_stat [NP];
    logic [NP*PW-1:0] hist   [0:1023];
    int               m_edges;

    task automatic model_clear();
        for (int p = 0; p < NP; p++) begin
            m_data[p] = '0; m_dir[p] = '0; m_ren[p] = '0; m_fen[p] = '0; m_stat[p] = '0;
        end
        m_edges = 0;
    endtask

    // Synchronised pin value visible after clock edge m (edges counted from reset release).
    function automatic logic [NP*PW-1:0] sync_after(int m);
        int k;
        k = m - SS + 1;
        if (k < 1) return '0;
        return hist[k];
    endfunction

    function automatic logic [31:0] model_rd(logic sel, logic [31:0] a);
        int p;
        logic [2:0] o3;
        logic [NP*PW-1:0] s;
        logic [PW-1:0] pin, v;
        if (!sel) return 32'h0;
        p  = int'(a[7:5]);
        o3 = a[4:2];
        if (p >= NP) return 32'h0;
        s   = sync_after(m_edges);
        pin = s[p*PW +: PW];
        case (o3)
            3'd0: v = (m_data[p] & m_dir[p]) | (pin & ~m_dir[p]);
            3'd1: v = m_dir[p];
            3'd2: v = m_ren[p];
            3'd3: v = m_fen[p];
            3'd4: v = m_stat[p];
            3'd5: v = pin;
            default: v = '0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [NP*PW-1:0] model_out();
        logic [NP*PW-1:0] r;
        for (int p = 0; p < NP; p++) r[p*PW +: PW] = m_data[p] & m_dir[p];
        return r;
    endfunction

    function automatic logic model_irq();
        logic r;
        r = 1'b0;
        for (int p = 0; p < NP; p++) r = r | (|m_stat[p]);
        return r;
    endfunction

    // Advance one clock: apply the bus write and edge capture of this cycle to the model.
    task automatic tick();
        int n, ip;
        logic armed;
        logic [NP*PW-1:0] cur, old;
        logic [PW-1:0] c, o;
        logic [PW-1:0] nd [NP];
        logic [PW-1:0] ndir [NP];
        logic [PW-1:0] nren [NP];
        logic [PW-1:0] nfen [NP];
        logic [PW-1:0] nstat [NP];
        logic [PW-1:0] mask [NP];
        n = m_edges + 1;
        if (n < 1024) hist[n] = port_in;
        cur   = sync_after(n - 1);
        old   = sync_after(n - 2);
        armed = (n > SS + 1);
        for (int p = 0; p < NP; p++) begin
            nd[p] = m_data[p]; ndir[p] = m_dir[p]; nren[p] = m_ren[p]; nfen[p] = m_fen[p];
            mask[p] = '0;
        end
        if (bus.Sel && bus.WE) begin
            ip = int'(bus.A[7:5]);
            if (ip < NP) begin
                case (bus.A[4:2])
                    3'd0: nd[ip]   = bus.WD[PW-1:0];
                    3'd1: ndir[ip] = bus.WD[PW-1:0];
                    3'd2: nren[ip] = bus.WD[PW-1:0];
                    3'd3: nfen[ip] = bus.WD[PW-1:0];
                    3'd4: mask[ip] = bus.WD[PW-1:0];
                    default: ;
                endcase
            end
        end
        for (int p = 0; p < NP; p++) begin
            c = cur[p*PW +: PW];
            o = old[p*PW +: PW];
            nstat[p] = (m_stat[p] & ~mask[p]) |
                       (armed ? ((c & ~o & m_ren[p]) | (~c & o & m_fen[p])) : '0);
        end
        @(posedge clk);
        for (int p = 0; p < NP; p++) begin
            m_data[p] = nd[p]; m_dir[p] = ndir[p]; m_ren[p] = nren[p];
            m_fen[p] = nfen[p]; m_stat[p] = nstat[p];
        end
        m_edges = n;
        #1;
    endtask

    function automatic logic [31:0] addr(int p, int off);
        return 32'(p * 32 + off * 4);
    endfunction

    task automatic bus_idle();
        bus.Sel = 1'b0; bus.WE = 1'b0; bus.A = '0; bus.WD = '0;
        bus_w.Sel = 1'b0; bus_w.WE = 1'b0; bus_w.A = '0; bus_w.WD = '0;
    endtask

    task automatic wr(int p, int off, logic [31:0] d);
        bus.Sel = 1'b1; bus.WE = 1'b1; bus.A = addr(p, off); bus.WD = d;
        tick();
        bus_idle();
    endtask

    task automatic rd(int p, int off, output logic [31:0] v);
        bus.Sel = 1'b1; bus.WE = 1'b0; bus.A = addr(p, off);
        #1;
        v = bus.RD;
        bus_idle();
    endtask

    task automatic wr_w(int p, int off, logic [31:0] d);
        bus_w.Sel = 1'b1; bus_w.WE = 1'b1; bus_w.A = addr(p, off); bus_w.WD = d;
        tick();
        bus_idle();
    endtask

    task automatic rd_w(int p, int off, output logic [31:0] v);
        bus_w.Sel = 1'b1; bus_w.WE = 1'b0; bus_w.A = addr(p, off);
        #1;
        v = bus_w.RD;
        bus_idle();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        bus_idle();
        port_in   = '1;
        port_in_w = '0;
        rst = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (port_out !== '0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got out=%h irq=%b expected out=0 irq=0", port_out, irq);
        end
        n_checks++;
        if (tap_data !== '0 || tap_ctrl !== '0 || bus.RD !== 32'h0) begin
            n_fail++; $display("FAIL reset_taps: got data=%h ctrl=%h rd=%h expected all 0", tap_data, tap_ctrl, bus.RD);
        end
        rst = 1'b0;
        repeat (6) tick();
        rd(0, 4, v);
        n_checks++;
        if (v !== 32'h0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_arm_status: got status=%h irq=%b expected 0/0", v, irq);
        end
        rd(0, 5, v);
        n_checks++;
        if (v !== 32'h0000_00FF) begin
            n_fail++; $display("FAIL reset_pin: got %h expected 000000ff", v);
        end
        n_checks++;
        if (port_out !== '0) begin
            n_fail++; $display("FAIL reset_portout: got %h expected 0", port_out);
        end
    endtask

    task automatic test_data_dir();
        logic [31:0] v;
        port_in = 16'h0030;
        wr(0, 1, 32'h0000_000F);
        wr(0, 0, 32'h0000_00A5);
        n_checks++;
        if (port_out[7:0] !== 8'h05 || tap_ctrl[31:0] !== 32'h0000_000F) begin
            n_fail++; $display("FAIL data_dir_out: got out=%h dirtap=%h expected 05/0000000f", port_out[7:0], tap_ctrl[31:0]);
        end
        repeat (2) tick();
        rd(0, 0, v);
        n_checks++;
        if (v !== 32'h0000_0035 || tap_data[31:0] !== 32'h0000_0035) begin
            n_fail++; $display("FAIL data_readback: got rd=%h tap=%h expected 00000035", v, tap_data[31:0]);
        end
    endtask

    task automatic test_rise_irq();
        logic [31:0] v;
        wr(1, 2, 32'h0000_0001);
        port_in[8] = 1'b0;
        repeat (3) tick();
        port_in[8] = 1'b1;
        tick();
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL rise_irq_k: got %b expected 0", irq);
        end
        tick();
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL rise_irq_k1: got %b expected 0", irq);
        end
        tick();
        rd(1, 4, v);
        n_checks++;
        if (irq !== 1'b1 || v !== 32'h0000_0001) begin
            n_fail++; $display("FAIL rise_irq_k2: got irq=%b status=%h expected 1/00000001", irq, v);
        end
        wr(1, 4, 32'h0000_0001);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL rise_w1c: got irq=%b expected 0", irq);
        end
    endtask

    task automatic test_fall_w1c();
        logic [31:0] v;
        wr(0, 3, 32'h0000_0080);
        port_in[7] = 1'b1;
        repeat (3) tick();
        port_in[7] = 1'b0;
        repeat (2) tick();
        wr(0, 4, 32'h0000_0080);
        rd(0, 4, v);
        n_checks++;
        if (v !== 32'h0000_0080 || v !== model_rd(1'b1, addr(0, 4)) || irq !== 1'b1) begin
            n_fail++; $display("FAIL fall_set_wins: got status=%h irq=%b expected 00000080/1", v, irq);
        end
        wr(0, 4, 32'h0000_0080);
        rd(0, 4, v);
        n_checks++;
        if (v !== 32'h0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL fall_clear: got status=%h irq=%b expected 0/0", v, irq);
        end
    endtask

    task automatic test_random();
        logic [31:0] r, exp_rd;
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            port_in = 16'($urandom);
            r = $urandom;
            bus.Sel = ($urandom_range(0, 3) != 0);
            bus.WE  = 1'($urandom_range(0, 1));
            bus.A   = {r[31:8], 3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), r[1:0]};
            bus.WD  = $urandom;
            #1;
            exp_rd = model_rd(bus.Sel, bus.A);
            n_checks++;
            if (bus.RD !== exp_rd) begin
                n_fail++; bad++;
                if (bad < 10) $display("FAIL rand_rd[%0d]: got %h expected %h", i, bus.RD, exp_rd);
            end
            n_checks++;
            if (port_out !== model_out() || irq !== model_irq() ||
                tap_ctrl[7:0] !== m_dir[0] || tap_ctrl[39:32] !== m_dir[1]) begin
                n_fail++; bad++;
                if (bad < 10) $display("FAIL rand_pins[%0d]: got out=%h irq=%b expected out=%h irq=%b",
                                       i, port_out, irq, model_out(), model_irq());
            end
            tick();
            bus_idle();
        end
    endtask

    task automatic test_wide();
        logic [31:0] v;
        wr_w(5, 0, 32'hFFFF_FFFF);
        wr_w(5, 1, 32'hFFFF_FFFF);
        rd_w(5, 0, v);
        n_checks++;
        if (v !== 32'h0 || tap_data_w !== '0 || tap_ctrl_w !== '0 || port_out_w !== '0) begin
            n_fail++; $display("FAIL wide_bad_port: got rd=%h taps=%h/%h out=%h expected all 0", v, tap_data_w, tap_ctrl_w, port_out_w);
        end
        wr_w(2, 1, 32'hFFFF_FFFF);
        wr_w(2, 0, 32'hFFFF_FFFF);
        rd_w(2, 0, v);
        n_checks++;
        if (v !== 32'h0000_0FFF) begin
            n_fail++; $display("FAIL wide_data_mask: got %h expected 00000fff", v);
        end
        rd_w(2, 1, v);
        n_checks++;
        if (v !== 32'h0000_0FFF || port_out_w !== {12'hFFF, 24'h0}) begin
            n_fail++; $display("FAIL wide_dir_out: got dir=%h out=%h expected 00000fff/fff000000", v, port_out_w);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        wr(0, 2, 32'h0000_000F);
        wr(0, 3, 32'h0);
        wr(1, 2, 32'h0);
        wr(1, 3, 32'h0);
        port_in = 16'h0000;
        repeat (3) tick();
        wr(0, 4, 32'h0000_00FF);
        wr(1, 4, 32'h0000_00FF);
        port_in = 16'h000F;
        repeat (3) tick();
        wr(0, 1, 32'h0000_00FF);
        rd(0, 4, v);
        n_checks++;
        if (v !== 32'h0000_000F || v !== model_rd(1'b1, addr(0, 4)) || irq !== 1'b1) begin
            n_fail++; $display("FAIL mid_setup: got status=%h irq=%b expected 0000000f/1", v, irq);
        end
        #2;
        rst = 1'b1;
        bus.Sel = 1'b1; bus.WE = 1'b0; bus.A = addr(0, 4);
        #1;
        n_checks++;
        if (port_out !== '0 || irq !== 1'b0 || bus.RD !== 32'h0 || tap_data !== '0 || tap_ctrl !== '0) begin
            n_fail++; $display("FAIL mid_reset_async: got out=%h irq=%b rd=%h tapd=%h tapc=%h expected all 0",
                               port_out, irq, bus.RD, tap_data, tap_ctrl);
        end
        bus.WE = 1'b1; bus.A = addr(0, 1); bus.WD = 32'h0000_00FF;
        @(posedge clk);
        #1;
        bus_idle();
        model_clear();
        rst = 1'b0;
        repeat (2) tick();
        rd(0, 1, v);
        n_checks++;
        if (v !== 32'h0 || port_out !== '0 || tap_ctrl !== '0) begin
            n_fail++; $display("FAIL mid_write_dropped: got dir=%h out=%h expected 0/0", v, port_out);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        test_reset();
        test_data_dir();
        test_rise_irq();
        test_fall_w1c();
        test_random();
        test_wide();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_gpio_bank.md
Name: mmio_gpio_bank

Overview:
- Parametrised successor to the fixed two-port memory-mapped I/O in the data-memory path: NUM_PORTS identical GPIO ports of PORT_WIDTH bits each.
- Each port has per-bit direction, input synchronisation, rise/fall edge capture into write-1-to-clear status, and a combined interrupt line.
- Sits beside data memory on the CPU memory interface. It is selected by the memory decode and stepped by the debounced CPU clock.
- Flattened tap outputs feed the peek display.

Parameters:
- NUM_PORTS, 2, number of GPIO ports (1..8).
- PORT_WIDTH, 8, bits per port (1..32).
- SYNC_STAGES, 2, input synchroniser depth (2..3).

Ports:
- CLK  in  1  CPU clock (debounced step clock at top level).
- reset  in  1  asynchronous, active-high reset.
- Sel  in  1  address falls in this block's window (from memory decode).
- WE  in  1  write enable, qualified by Sel.
- A  in  32  byte address; only A[4:2] (register) and A[7:5] (port) used.
- WD  in  32  write data.
- RD  out  32  read data, combinational.
- PortIn  in  NUM_PORTS*PORT_WIDTH  external inputs; port p occupies bits [p*PORT_WIDTH +: PORT_WIDTH].
- PortOut  out  NUM_PORTS*PORT_WIDTH  driven pin values.
- IRQ  out  1  OR of all pending enabled status bits.
- TapData  out  NUM_PORTS*32  DATA register view per port.
- TapControl  out  NUM_PORTS*32  DIR register per port.

Behaviour:
- Register map per port, stride 32 bytes, offset = A[4:2]:
  - 0 DATA: RW.
  - 1 DIR: RW; bit=1 means output.
  - 2 RISE_EN: RW.
  - 3 FALL_EN: RW.
  - 4 STATUS: read; write-1-to-clear.
  - 5 PIN: RO; synchronised input.
  - 6..7: reserved, read 0.
- Register width:
  - Only bits [PORT_WIDTH-1:0] are stored.
  - Upper bits read 0 and ignore writes.
- Port index decode:
  - A port index >= NUM_PORTS reads 0 and ignores writes.
- Writes:
  - Occur on the CLK rising edge when Sel&WE.
  - Writes to PIN and reserved offsets are ignored.
- Reads:
  - RD is combinational from Sel and A.
  - RD = 0 when Sel=0.
  - DATA read returns (out_latch & DIR) | (pin_sync & ~DIR).
- PortOut = out_latch & DIR per port; input-direction bits drive 0.
- Synchroniser and edge timing:
  - Each PortIn bit passes through SYNC_STAGES flops, giving pin_sync.
  - prev flop holds pin_sync from the previous cycle.
  - rise = pin_sync & ~prev & RISE_EN.
  - fall = ~pin_sync & prev & FALL_EN.
  - With SYNC_STAGES=2: a pin change sampled at edge k is visible in PIN/DATA after edge k+1, and STATUS is set at edge k+2.
  - IRQ is combinational from STATUS, so it asserts in the same cycle.
- STATUS update:
  - status_next = (status & ~(W1C mask)) | rise | fall.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - Edge detection runs on all bits regardless of DIR. Output bits see a synchronised 0 because their pins are not looped back.
- Arming after reset:
  - An armed flag is cleared by reset.
  - It is set after SYNC_STAGES+1 clocks following reset deassertion.
  - While unarmed, rise/fall are forced to 0, so an input held high through reset sets no status.
- Reset values (asynchronous):
  - All DATA/DIR/RISE_EN/FALL_EN/STATUS registers, sync flops, prev flops and armed = 0.
  - Hence PortOut=0, IRQ=0, RD=0 with Sel low, all taps 0.
- Reset mid-operation:
  - Immediate clear of every register and flop.
  - Pending status is lost.
  - Any in-flight write is dropped.

Decomposition:
- Package gpio_pkg holds:
  - register offset constants (OFF_DATA..OFF_PIN);
  - PORT_STRIDE_BYTES=32;
  - an enum for register index.
- Sub-module gpio_port holds one port's registers, synchroniser, edge detect and status.
  - The top generates NUM_PORTS instances.
  - The top handles decode, the read mux and the IRQ reduction.

Test Plan:
- Reset with PortIn=all 1s -> 6 clocks after deassert STATUS=0, IRQ=0, PIN reads 0xFF (port0); PortOut=0.
- Write DIR0=0x0F, DATA0=0xA5 -> PortOut[7:0]=0x05; DATA0 readback with PortIn[7:0]=0x30 is 0x35.
- RISE_EN1=0x01, toggle PortIn[8] 0->1 at edge k -> STATUS1 reads 0x01 and IRQ=1 from edge k+2. Write STATUS1=0x01 -> IRQ=0 the next cycle.
- FALL_EN0=0x80, fall on bit7 coinciding with a W1C write 0x80 -> STATUS0 bit7 stays 1.
- NUM_PORTS=3, PORT_WIDTH=12: write to port index 5 -> no register changes, RD=0. Write 0xFFFFFFFF to DATA2 -> reads 0x00000FFF masked by DIR.
- Assert reset mid-run with STATUS0=0x0F and DIR0=0xFF -> all outputs 0 immediately, before the next CLK edge.
